// File: rtl/divider_mem_datapath_param.sv
// Scratch-memory datapath: gathers CDF operands from read beats, launches NUM_DIV dividers and
// packs their quotients into write beats. Define DIVMEM_SAT_EN to clamp quotients at SAT_MAX.
module divider_mem_datapath_param #(
  parameter int unsigned NUM_DIV = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_W   = 128,
  parameter int unsigned SAT_MAX = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sc_mem_rd_data_rdy,
  input  logic [MEM_W-1:0]          sc_mem_rd_data,
  output logic                      div_start,
  output logic [NUM_DIV*DATA_W-1:0] cdfval_todiv,
  input  logic [NUM_DIV-1:0]        div_done,
  input  logic [NUM_DIV*DATA_W-1:0] div_value,
  output logic                      sc_mem_wt_valid,
  input  logic                      sc_mem_wt_ready,
  output logic [MEM_W-1:0]          sc_mem_wt_data,
  output logic                      sc_mem_wt_last,
  output logic                      busy
);

  localparam int unsigned LANES = MEM_W / DATA_W;
  localparam int unsigned BEATS = NUM_DIV / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned VEC_W = NUM_DIV * DATA_W;
`ifdef DIVMEM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic [DATA_W-1:0] SAT_V    = DATA_W'(SAT_MAX);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [VEC_W-1:0]   cdf_q, cdf_d;
  logic [VEC_W-1:0]   quot_q, quot_d;
  logic [NUM_DIV-1:0] done_seen_q, done_seen_d;
  logic               div_start_q, div_start_d;
  logic               wt_valid_q, wt_valid_d;
  logic               wt_last_q, wt_last_d;
  logic [MEM_W-1:0]   wt_data_q, wt_data_d;
  logic               busy_q, busy_d;

  logic rd_accept;
  logic wt_accept;
  logic rd_last;
  logic wr_last;

  function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v);
    return (SAT_EN && (v > SAT_V)) ? SAT_V : v;
  endfunction

  assign rd_accept = (state_q == S_FILL) && sc_mem_rd_data_rdy;
  assign wt_accept = (state_q == S_WRITE) && sc_mem_wt_ready;
  assign rd_last   = (rd_cnt_q == LAST_CNT);
  assign wr_last   = (wr_cnt_q == LAST_CNT);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      cdf_q       <= '0;
      quot_q      <= '0;
      done_seen_q <= '0;
      div_start_q <= 1'b0;
      wt_valid_q  <= 1'b0;
      wt_last_q   <= 1'b0;
      wt_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      cdf_q       <= cdf_d;
      quot_q      <= quot_d;
      done_seen_q <= done_seen_d;
      div_start_q <= div_start_d;
      wt_valid_q  <= wt_valid_d;
      wt_last_q   <= wt_last_d;
      wt_data_q   <= wt_data_d;
      busy_q      <= busy_d;
    end
  end

  // Operand gather, first-done quotient capture and beat counters
  always_comb begin
    cdf_d       = cdf_q;
    quot_d      = quot_q;
    done_seen_d = done_seen_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (rd_accept) begin
      for (int b = 0; b < BEATS; b++) begin
        if (rd_cnt_q == CNT_W'(b)) cdf_d[b*MEM_W +: MEM_W] = sc_mem_rd_data;
      end
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + CNT_W'(1);
    end
    if (state_q == S_WAIT) begin
      for (int c = 0; c < NUM_DIV; c++) begin
        if (div_done[c] && !done_seen_q[c])
          quot_d[c*DATA_W +: DATA_W] = clamp(div_value[c*DATA_W +: DATA_W]);
      end
      done_seen_d = done_seen_q | div_done;
    end
    if (wt_accept) begin
      if (wr_last) begin
        wr_cnt_d    = '0;
        done_seen_d = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_FILL;
      S_FILL:  if (rd_accept && rd_last) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (&done_seen_d) state_d = S_WRITE;
      S_WRITE: if (wt_accept && wr_last) state_d = enable ? S_FILL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it as registers
  always_comb begin
    div_start_d = (state_d == S_ISSUE);
    wt_valid_d  = (state_d == S_WRITE);
    wt_last_d   = wt_valid_d && (wr_cnt_d == LAST_CNT);
    busy_d      = (state_d != S_IDLE);
    wt_data_d   = '0;
    if (wt_valid_d) begin
      for (int b = 0; b < BEATS; b++) begin
        if (wr_cnt_d == CNT_W'(b)) wt_data_d = quot_d[b*MEM_W +: MEM_W];
      end
    end
  end

  assign div_start       = div_start_q;
  assign cdfval_todiv    = cdf_q;
  assign sc_mem_wt_valid = wt_valid_q;
  assign sc_mem_wt_data  = wt_data_q;
  assign sc_mem_wt_last  = wt_last_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_divider_mem_datapath_param.sv
// Scoreboard bench for divider_mem_datapath_param: random batches against a batch-level model;
// honours DIVMEM_SAT_EN when defined for the build.
module tb_divider_mem_datapath_param;

  localparam int unsigned NUM_DIV = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_W   = 128;
  localparam int unsigned BEATS   = 2;
  localparam int unsigned SAT_MAX = 255;
  localparam int unsigned VEC_W   = NUM_DIV * DATA_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t warr_t [NUM_DIV];
  typedef int iarr_t [NUM_DIV];
  typedef struct packed {
    logic [MEM_W-1:0] data;
    logic             last;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               rd_rdy;
  logic [MEM_W-1:0]   rd_data;
  logic               div_start;
  logic [VEC_W-1:0]   cdfval_todiv;
  logic [NUM_DIV-1:0] div_done;
  logic [VEC_W-1:0]   div_value;
  logic               wt_valid;
  logic               wt_ready;
  logic [MEM_W-1:0]   wt_data;
  logic               wt_last;
  logic               busy;

  divider_mem_datapath_param #(
    .NUM_DIV(NUM_DIV), .DATA_W(DATA_W), .MEM_W(MEM_W), .SAT_MAX(SAT_MAX)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sc_mem_rd_data_rdy(rd_rdy), .sc_mem_rd_data(rd_data),
    .div_start(div_start), .cdfval_todiv(cdfval_todiv),
    .div_done(div_done), .div_value(div_value),
    .sc_mem_wt_valid(wt_valid), .sc_mem_wt_ready(wt_ready),
    .sc_mem_wt_data(wt_data), .sc_mem_wt_last(wt_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_checks  = 0;
  int    n_fail    = 0;
  int    starts    = 0;
  int    n_batches = 0;
  int    rdy_mode  = 0;
  int    hold_cnt  = 0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t model_q(input word_t v);
`ifdef DIVMEM_SAT_EN
    return (v > word_t'(SAT_MAX)) ? word_t'(SAT_MAX) : v;
`else
    return v;
`endif
  endfunction

  // Write-side ready generator
  initial begin
    wt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       wt_ready = 1'b1;
        1:       wt_ready = 1'($urandom_range(0, 1));
        default: wt_ready = (hold_cnt >= 5);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted write beat and checks stall stability
  logic             prev_stall = 1'b0;
  logic [MEM_W-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      if (prev_stall) begin
        check("stall_valid", VEC_W'(wt_valid), VEC_W'(1));
        check("stall_data", VEC_W'(wt_data), VEC_W'(prev_data));
        check("stall_last", VEC_W'(wt_last), VEC_W'(prev_last));
      end
      if (wt_valid && wt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got data %h with no beat expected", wt_data);
        end else begin
          e = exp_q.pop_front();
          check("wt_data", VEC_W'(wt_data), VEC_W'(e.data));
          check("wt_last", VEC_W'(wt_last), VEC_W'(e.last));
        end
      end
      if (rdy_mode == 2 && wt_valid && !wt_ready) hold_cnt++;
      if (div_start) starts++;
    end
    prev_stall = reset && wt_valid && !wt_ready;
    prev_data  = wt_data;
    prev_last  = wt_last;
  end

  // Enable a batch from IDLE (with an ignored read beat), deliver both beats with random gaps
  task automatic fill(input warr_t cdf, output logic [VEC_W-1:0] flat);
    for (int c = 0; c < NUM_DIV; c++) flat[c*DATA_W +: DATA_W] = cdf[c];
    n_batches++;
    @(posedge clk);
    #1;
    rd_rdy  = 1'b1;
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    enable  = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      repeat ($urandom_range(0, 2)) begin
        rd_rdy    = 1'b0;
        rd_data   = {$urandom, $urandom, $urandom, $urandom};
        div_done  = NUM_DIV'($urandom);
        div_value = {8{$urandom}};
        @(posedge clk);
        #1;
      end
      rd_rdy  = 1'b1;
      rd_data = flat[b*MEM_W +: MEM_W];
      @(posedge clk);
      #1;
    end
    rd_rdy = 1'b0;
    @(negedge clk);
    check("div_start_pulse", VEC_W'(div_start), VEC_W'(1));
    check("cdfval", cdfval_todiv, flat);
  endtask

  task automatic run_batch(input warr_t cdf, input warr_t val, input iarr_t td);
    logic [VEC_W-1:0] flat;
    logic [VEC_W-1:0] qf;
    beat_t            bt;
    int               tmax;
    tmax = 0;
    for (int c = 0; c < NUM_DIV; c++) begin
      qf[c*DATA_W +: DATA_W] = model_q(val[c]);
      if (td[c] > tmax) tmax = td[c];
    end
    fill(cdf, flat);
    for (int k = 0; k < BEATS; k++) begin
      bt.data = qf[k*MEM_W +: MEM_W];
      bt.last = (k == BEATS - 1);
      exp_q.push_back(bt);
    end
    for (int t = 0; t <= tmax + 1; t++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_DIV; c++) begin
        if (t == td[c]) begin
          div_done[c] = 1'b1;
          div_value[c*DATA_W +: DATA_W] = val[c];
        end else begin
          div_done[c] = (t > td[c]) ? 1'($urandom_range(0, 1)) : 1'b0;
          div_value[c*DATA_W +: DATA_W] = $urandom;
        end
      end
      @(negedge clk);
      check("write_entry", VEC_W'(wt_valid), VEC_W'(t == tmax + 1));
      if (t == 0) check("div_start_single", VEC_W'(div_start), VEC_W'(0));
    end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: %0d beats still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    div_done = '0;
    @(negedge clk);
    check("idle_busy", VEC_W'(busy), VEC_W'(0));
    check("cdf_hold", cdfval_todiv, flat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, VEC_W'(busy), VEC_W'(0));
    check({tag, "_div_start"}, VEC_W'(div_start), VEC_W'(0));
    check({tag, "_wt_valid"}, VEC_W'(wt_valid), VEC_W'(0));
    check({tag, "_wt_data"}, VEC_W'(wt_data), VEC_W'(0));
    check({tag, "_wt_last"}, VEC_W'(wt_last), VEC_W'(0));
    check({tag, "_cdfval"}, cdfval_todiv, VEC_W'(0));
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    warr_t            cdf;
    warr_t            val;
    iarr_t            td;
    logic [VEC_W-1:0] flat;
    reset = 1'b0; enable = 1'b0; rd_rdy = 1'b0; rd_data = '0;
    div_done = '0; div_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed: operands 32/33, all channels done together with quotient 1
    rdy_mode = 0;
    for (int c = 0; c < NUM_DIV; c++) begin
      cdf[c] = (c < 4) ? 32'd32 : 32'd33;
      val[c] = 32'd1;
      td[c]  = 0;
    end
    run_batch(cdf, val, td);

    // Directed: reverse-order completion, distinct quotients 0..70
    for (int c = 0; c < NUM_DIV; c++) begin
      cdf[c] = $urandom;
      val[c] = word_t'(10 * c);
      td[c]  = 7 - c;
    end
    run_batch(cdf, val, td);

    // Directed: write ready held low for five cycles on the first beat
    rdy_mode = 2;
    hold_cnt = 0;
    for (int c = 0; c < NUM_DIV; c++) begin
      cdf[c] = $urandom;
      val[c] = $urandom_range(0, 200);
      td[c]  = $urandom_range(0, 3);
    end
    run_batch(cdf, val, td);
    check("hold_cycles", VEC_W'(hold_cnt), VEC_W'(5));

    // Directed: reset in WAIT after three channels completed
    rdy_mode = 0;
    for (int c = 0; c < NUM_DIV; c++) cdf[c] = $urandom;
    fill(cdf, flat);
    @(posedge clk);
    #1;
    div_done  = 8'b0000_0111;
    div_value = {8{$urandom}};
    @(posedge clk);
    #1;
    div_done = '0;
    reset    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", VEC_W'(busy), VEC_W'(0));

    // Directed: channel 2 quotient above the clamp ceiling
    for (int c = 0; c < NUM_DIV; c++) begin
      cdf[c] = $urandom;
      val[c] = (c == 2) ? 32'd300 : word_t'($urandom_range(0, 255));
      td[c]  = $urandom_range(0, 2);
    end
    run_batch(cdf, val, td);

    // Random batches with random write backpressure
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      for (int c = 0; c < NUM_DIV; c++) begin
        cdf[c] = $urandom;
        val[c] = $urandom_range(0, 1) ? $urandom : word_t'($urandom_range(0, 600));
        td[c]  = $urandom_range(0, 6);
      end
      run_batch(cdf, val, td);
    end

    repeat (2) @(negedge clk);
    check("div_start_count", VEC_W'(starts), VEC_W'(n_batches));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_mem_datapath_param.md
Name: divider_mem_datapath_param

Overview:
Parametrised successor to the fixed 8-divider scratch-memory datapath in the CDF/equalisation pipeline. It gathers CDF values from scratch-memory read beats and distributes one value to each of NUM_DIV divider channels. It waits for every channel's done with per-channel sticky tracking, then packs the quotients into scratch-memory write beats under a valid/ready handshake. Unlike the previous generation, it supports generic widths and channel counts, out-of-order divider completion and write backpressure.

Parameters:
NUM_DIV, 8, number of divider channels; must be a multiple of LANES
DATA_W, 32, width of one CDF value and of one quotient
MEM_W, 128, scratch-memory beat width; LANES = MEM_W/DATA_W (must divide exactly); BEATS = NUM_DIV/LANES
SAT_MAX, 255, clamp ceiling used only when DIVMEM_SAT_EN is defined

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  allows a new batch to start; a batch in progress always completes
sc_mem_rd_data_rdy  in  1  read beat valid this cycle
sc_mem_rd_data  in  MEM_W  read beat; lane i = bits [i*DATA_W +: DATA_W]
div_start  out  1  one-cycle pulse launching all dividers
cdfval_todiv  out  NUM_DIV*DATA_W  channel c operand at [c*DATA_W +: DATA_W]
div_done  in  NUM_DIV  per-channel done (level or pulse)
div_value  in  NUM_DIV*DATA_W  per-channel quotient, valid while its done is high
sc_mem_wt_valid  out  1  write beat valid
sc_mem_wt_ready  in  1  memory accepts write beat
sc_mem_wt_data  out  MEM_W  packed quotients
sc_mem_wt_last  out  1  high on final write beat of a batch
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, beat counters 0, cdfval_todiv=0, captured quotients=0, done_seen=0, div_start=0, sc_mem_wt_valid=0, sc_mem_wt_data=0, sc_mem_wt_last=0, busy=0. Applies from any state; a batch in progress is discarded and no write is issued.
- IDLE: if enable=1, go to FILL next cycle. Read beats in IDLE are ignored.
- FILL: each cycle with sc_mem_rd_data_rdy=1 accepts one beat. Beat b, lane i loads channel b*LANES+i. After the beat with b=BEATS-1 is accepted, go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle, then go to WAIT. cdfval_todiv holds stable from the last FILL load until the next batch's FILL.
- WAIT:
  - done_seen[c] |= div_done[c].
  - div_value[c] is captured only on the first cycle div_done[c]=1 while done_seen[c]=0; later values are ignored.
  - Channels may complete in any order, and simultaneously.
  - The cycle after done_seen is all-ones, go to WRITE.
  - div_done outside WAIT is ignored.
- WRITE:
  - sc_mem_wt_valid=1; sc_mem_wt_data = quotients of channels k*LANES..k*LANES+LANES-1, lane order as on read.
  - sc_mem_wt_last=1 when k=BEATS-1.
  - Data is held stable while sc_mem_wt_ready=0.
  - When valid and ready are both 1, k increments; the next beat appears the following cycle.
  - On acceptance of the last beat, clear done_seen and k. Go to FILL if enable=1, else IDLE.
- Start latency: last read beat accepted at cycle N gives div_start at N+1. All done seen at cycle M gives the first write beat at M+1.
- Read beats arriving in ISSUE/WAIT/WRITE are dropped; the producer must hold until busy returns to FILL.
- Quotient width is DATA_W, with no truncation unless the optional feature is enabled.

Optional Feature:
Macro DIVMEM_SAT_EN.
- Defined: each captured quotient greater than SAT_MAX is stored as SAT_MAX (unsigned compare); values at or below SAT_MAX pass unchanged.
- Undefined: quotients are stored verbatim and SAT_MAX is unused.

Test Plan:
- Reset then enable=1; read beats {4x32'd32} and {4x32'd33} -> cdfval_todiv ch0-3=32, ch4-7=33; div_start pulses exactly once, one cycle after the second beat.
- All 8 div_done=1 together with div_value=1, sc_mem_wt_ready=1 -> two write beats of 128'h00000001_00000001_00000001_00000001; wt_last on the second beat only.
- div_done raised one channel per cycle in reverse order 7..0 with distinct values 70..0 -> WRITE entered one cycle after ch0; lanes carry 0,10,..,70 in channel order.
- sc_mem_wt_ready=0 for 5 cycles during beat 0 -> wt_data and wt_valid held constant; beat 1 appears only after the ready handshake.
- reset driven low during WAIT with 3 channels done -> all outputs return to reset values next cycle; no write issued; a fresh batch runs correctly afterwards.
- DIVMEM_SAT_EN defined, div_value=300 on ch2 -> stored lane value is 255. Without the macro, the stored value is 300.
